mem_traffic_initiator: RTL and testbench

- Request-side counterpart of the memory controller. Drives its write/read request ports and consumes its write/read return channels.
- Writes a block of addresses with a known data pattern, then reads the block back with a bounded number of reads outstanding.
- Matches each return by tag (tag = address) and self-checks the returned data. Reports pass/fail and counters.
- Used as the synthesizable stimulus/checker for the simulator top level.

---
 rtl/mem_traffic_initiator.sv | 191 +++++++++++++++++++
 tb/tb_mem_traffic_initiator.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_traffic_initiator.sv
// Memory traffic initiator: writes a block of addresses with a keyed data
// pattern, reads the block back with a bounded number of reads in flight,
// matches each read return by tag and checks its data.
module mem_traffic_initiator #(
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter int          NUM_REQ         = 64,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [15:0] DATA_KEY        = 16'hA5C3,
  parameter bit          WAIT_WR_ACK     = 1'b1,
  parameter int          TIMEOUT         = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] wr_address,
  output logic        wr_en,
  output logic [15:0] wr_data,
  input  logic [15:0] wr_ret_address,
  input  logic        wr_ret_ack,
  output logic [15:0] rd_address,
  output logic        rd_en,
  input  logic [15:0] rd_ret_data,
  input  logic [15:0] rd_ret_address,
  input  logic        rd_ret_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  rd_count,
  output logic [7:0]  err_count
);

  // Bitmap is rounded up to a power of two so any low-bit slice of a tag
  // indexes a real bit; only the first NUM_REQ bits are ever set.
  localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          BMW      = 1 << IW;
  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [8:0]  LAST_IDX = 9'(NUM_REQ - 1);
  localparam logic [8:0]  NREQ_W   = 9'(NUM_REQ);
  localparam logic [15:0] NREQ16   = 16'(NUM_REQ);
  localparam logic [7:0]  MAX_OUT8 = 8'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_DRAIN, S_READ, S_RD_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic [8:0]      idx;          // write index, then reused as read index
  logic [8:0]      wack_cnt;
  logic [7:0]      outstanding;
  logic [BMW-1:0]  bitmap;       // one bit per read in flight
  logic [TW-1:0]   tmo_cnt;

  logic [15:0] cur_addr, rd_k, wr_k;
  logic        rd_active, wr_active, rd_hit, rd_ok, rd_bad, wr_in, wr_ok, wr_bad;
  logic        issue, drain_idle, drain_fin, tmo_hit, err_inc;

  // Return decode: tag range / bitmap lookup, data check, issue and timeout.
  always_comb begin
    cur_addr   = BASE_ADDR + {7'd0, idx};
    rd_k       = rd_ret_address - BASE_ADDR;
    wr_k       = wr_ret_address - BASE_ADDR;
    rd_active  = (state == S_READ) || (state == S_RD_DRAIN);
    wr_active  = WAIT_WR_ACK && ((state == S_WRITE) || (state == S_WR_DRAIN));
    // A tag issued this very cycle still reads as 0 here: registered bitmap.
    rd_hit     = (rd_k < NREQ16) && bitmap[rd_k[IW-1:0]];
    rd_ok      = rd_active && rd_ret_ack && rd_hit;
    rd_bad     = rd_active && rd_ret_ack &&
                 (!rd_hit || (rd_ret_data != (rd_ret_address ^ DATA_KEY)));
    wr_in      = wr_k < NREQ16;
    wr_ok      = wr_active && wr_ret_ack && wr_in;
    wr_bad     = wr_active && wr_ret_ack && !wr_in;
    // Full check against the pre-update count: a return frees no slot
    // in the same cycle.
    issue      = (state == S_READ) && (outstanding < MAX_OUT8);
    drain_idle = ((state == S_WR_DRAIN) && !wr_ret_ack) ||
                 ((state == S_RD_DRAIN) && !rd_ret_ack);
    drain_fin  = ((state == S_WR_DRAIN) && (wack_cnt == NREQ_W)) ||
                 ((state == S_RD_DRAIN) && (outstanding == 8'd0));
    tmo_hit    = drain_idle && !drain_fin && (tmo_cnt == TMO_LAST);
    err_inc    = rd_bad || wr_bad || tmo_hit;
  end

  // Main FSM with registered request and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      wack_cnt    <= '0;
      outstanding <= '0;
      bitmap      <= '0;
      tmo_cnt     <= '0;
      wr_address  <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      rd_address  <= '0;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      rd_count    <= '0;
      err_count   <= '0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;

      // Return bookkeeping; only non-zero in states that accept returns.
      outstanding <= outstanding + {7'd0, issue} - {7'd0, rd_ok};
      if (rd_ok) begin
        bitmap[rd_k[IW-1:0]] <= 1'b0;
        rd_count             <= rd_count + 9'd1;
      end
      if (wr_ok)
        wack_cnt <= wack_cnt + 9'd1;
      if (err_inc) begin
        error <= 1'b1;
        if (err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_WRITE;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
            rd_count    <= '0;
            wack_cnt    <= '0;
            outstanding <= '0;
            bitmap      <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
          end
        end
        S_WRITE: begin
          wr_en      <= 1'b1;
          wr_address <= cur_addr;
          wr_data    <= cur_addr ^ DATA_KEY;
          if (idx == LAST_IDX) begin
            idx     <= '0;
            tmo_cnt <= '0;
            state   <= WAIT_WR_ACK ? S_WR_DRAIN : S_READ;
          end else begin
            idx <= idx + 9'd1;
          end
        end
        S_WR_DRAIN: begin
          if (drain_fin) begin
            state <= S_READ;
          end else if (tmo_hit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (wr_ret_ack) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_READ: begin
          if (issue) begin
            rd_en                  <= 1'b1;
            rd_address             <= cur_addr;
            bitmap[idx[IW-1:0]]    <= 1'b1;
            if (idx == LAST_IDX) begin
              state   <= S_RD_DRAIN;
              tmo_cnt <= '0;
            end else begin
              idx <= idx + 9'd1;
            end
          end
        end
        S_RD_DRAIN: begin
          if (drain_fin || tmo_hit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (rd_ret_ack) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_traffic_initiator.sv
// Directed bench: three initiator instances share one memory model; the
// idle instances sit in IDLE/DONE, where returns must be ignored.
module tb_mem_traffic_initiator;
  localparam logic [15:0] KEY = 16'hA5C3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b, start_c;
  logic [15:0] wr_ret_address = '0, rd_ret_data = '0, rd_ret_address = '0;
  logic        wr_ret_ack = 1'b0, rd_ret_ack = 1'b0;

  logic [15:0] a_wr_address, a_wr_data, a_rd_address;
  logic        a_wr_en, a_rd_en, a_busy, a_done, a_error;
  logic [8:0]  a_rd_count;
  logic [7:0]  a_err_count;
  logic [15:0] b_wr_address, b_wr_data, b_rd_address;
  logic        b_wr_en, b_rd_en, b_busy, b_done, b_error;
  logic [8:0]  b_rd_count;
  logic [7:0]  b_err_count;
  logic [15:0] c_wr_address, c_wr_data, c_rd_address;
  logic        c_wr_en, c_rd_en, c_busy, c_done, c_error;
  logic [8:0]  c_rd_count;
  logic [7:0]  c_err_count;

  mem_traffic_initiator #(.BASE_ADDR(16'h0010), .NUM_REQ(4), .MAX_OUTSTANDING(8),
    .DATA_KEY(KEY), .WAIT_WR_ACK(1'b1), .TIMEOUT(1024)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .wr_address(a_wr_address), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
    .rd_address(a_rd_address), .rd_en(a_rd_en),
    .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
    .busy(a_busy), .done(a_done), .error(a_error), .rd_count(a_rd_count), .err_count(a_err_count));

  mem_traffic_initiator #(.BASE_ADDR(16'h0010), .NUM_REQ(8), .MAX_OUTSTANDING(8),
    .DATA_KEY(KEY), .WAIT_WR_ACK(1'b1), .TIMEOUT(1024)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .wr_address(b_wr_address), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
    .rd_address(b_rd_address), .rd_en(b_rd_en),
    .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
    .busy(b_busy), .done(b_done), .error(b_error), .rd_count(b_rd_count), .err_count(b_err_count));

  mem_traffic_initiator #(.BASE_ADDR(16'h0010), .NUM_REQ(4), .MAX_OUTSTANDING(2),
    .DATA_KEY(KEY), .WAIT_WR_ACK(1'b1), .TIMEOUT(1024)) dut_c (
    .clk(clk), .reset(reset), .start(start_c),
    .wr_address(c_wr_address), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
    .rd_address(c_rd_address), .rd_en(c_rd_en),
    .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack),
    .busy(c_busy), .done(c_done), .error(c_error), .rd_count(c_rd_count), .err_count(c_err_count));

  // Selected instance feeds the memory model and the checks.
  int          sel = 0;
  logic        m_wr_en, m_rd_en, m_busy, m_done, m_error;
  logic [15:0] m_wr_address, m_wr_data, m_rd_address;
  logic [8:0]  m_rd_count;
  logic [7:0]  m_err_count;
  always_comb begin
    m_wr_en = a_wr_en; m_rd_en = a_rd_en; m_busy = a_busy; m_done = a_done; m_error = a_error;
    m_wr_address = a_wr_address; m_wr_data = a_wr_data; m_rd_address = a_rd_address;
    m_rd_count = a_rd_count; m_err_count = a_err_count;
    if (sel == 1) begin
      m_wr_en = b_wr_en; m_rd_en = b_rd_en; m_busy = b_busy; m_done = b_done; m_error = b_error;
      m_wr_address = b_wr_address; m_wr_data = b_wr_data; m_rd_address = b_rd_address;
      m_rd_count = b_rd_count; m_err_count = b_err_count;
    end else if (sel == 2) begin
      m_wr_en = c_wr_en; m_rd_en = c_rd_en; m_busy = c_busy; m_done = c_done; m_error = c_error;
      m_wr_address = c_wr_address; m_wr_data = c_wr_data; m_rd_address = c_rd_address;
      m_rd_count = c_rd_count; m_err_count = c_err_count;
    end
  end

  // Memory model. mode 0: in-order, 3-cycle latency, optional corrupt tag;
  // 1: never return reads; 2: hold rev_n reads, return newest first;
  // 3: hold reads, release up to rel_target in order. Injected returns win.
  int          mode = 0, corrupt_tag = -1, rev_n = 8, rel_target = 0, inj_target = 0;
  logic [15:0] inj_a [2];
  logic [15:0] inj_d [2];
  int          cyc = 0, rel_sent = 0, inj_sent = 0;
  bit          rev_go = 1'b0;
  int          wq_a[$], wq_t[$], rq_a[$], rq_t[$], hq[$];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    wr_ret_ack <= 1'b0;
    rd_ret_ack <= 1'b0;
    if (wq_t.size() > 0 && wq_t[0] <= cyc) begin
      wr_ret_ack     <= 1'b1;
      wr_ret_address <= 16'(wq_a[0]);
      void'(wq_a.pop_front());
      void'(wq_t.pop_front());
    end
    if (m_wr_en) begin
      wq_a.push_back(int'(m_wr_address));
      wq_t.push_back(cyc + 3);
    end
    if (inj_sent < inj_target) begin
      rd_ret_ack     <= 1'b1;
      rd_ret_address <= inj_a[inj_sent];
      rd_ret_data    <= inj_d[inj_sent];
      inj_sent       <= inj_sent + 1;
    end else if (mode == 0) begin
      if (rq_t.size() > 0 && rq_t[0] <= cyc) begin
        rd_ret_ack     <= 1'b1;
        rd_ret_address <= 16'(rq_a[0]);
        rd_ret_data    <= 16'(rq_a[0]) ^ KEY ^ ((rq_a[0] == corrupt_tag) ? 16'h0001 : 16'h0000);
        void'(rq_a.pop_front());
        void'(rq_t.pop_front());
      end
    end else if (mode == 2) begin
      if (rev_go && hq.size() > 0) begin
        rd_ret_ack     <= 1'b1;
        rd_ret_address <= 16'(hq[hq.size()-1]);
        rd_ret_data    <= 16'(hq[hq.size()-1]) ^ KEY;
        void'(hq.pop_back());
      end
    end else if (mode == 3) begin
      if (rel_sent < rel_target && hq.size() > 0) begin
        rd_ret_ack     <= 1'b1;
        rd_ret_address <= 16'(hq[0]);
        rd_ret_data    <= 16'(hq[0]) ^ KEY;
        void'(hq.pop_front());
        rel_sent       <= rel_sent + 1;
      end
    end
    if (m_rd_en) begin
      if (mode == 0) begin
        rq_a.push_back(int'(m_rd_address));
        rq_t.push_back(cyc + 3);
      end else if (mode >= 2) begin
        hq.push_back(int'(m_rd_address));
      end
    end
    if (mode == 2 && hq.size() >= rev_n) rev_go <= 1'b1;
    else if (hq.size() == 0)             rev_go <= 1'b0;
  end

  int checks = 0, errors = 0;
  logic [15:0] exp_wa [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
  logic [15:0] exp_wd [4] = '{16'hA5D3, 16'hA5D2, 16'hA5D1, 16'hA5D0};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    if (sel == 0) start_a = 1'b1;
    else if (sel == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int t = 0; t < bound && !m_done; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if ({a_wr_address, a_wr_en, a_wr_data, a_rd_address, a_rd_en, a_busy, a_done, a_error,
         a_rd_count, a_err_count} !== '0) begin
      errors++; $display("FAIL reset_a got busy=%b done=%b err=%b rdc=%0d want all 0", a_busy, a_done, a_error, a_rd_count);
    end
    checks++;
    if ({b_wr_en, b_rd_en, b_busy, b_done, b_error, b_rd_count, b_err_count, b_wr_address} !== '0) begin
      errors++; $display("FAIL reset_b got busy=%b done=%b want all 0", b_busy, b_done);
    end
    checks++;
    if ({c_wr_en, c_rd_en, c_busy, c_done, c_error, c_rd_count, c_err_count, c_rd_address} !== '0) begin
      errors++; $display("FAIL reset_c got busy=%b done=%b want all 0", c_busy, c_done);
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if ({a_busy, a_done, a_wr_en, a_rd_en} !== 4'b0) begin
      errors++; $display("FAIL idle_no_start got %b want 0000", {a_busy, a_done, a_wr_en, a_rd_en});
    end
  endtask

  task automatic test_inorder();
    int n_wr = 0, n_rd = 0, t = 0;
    sel = 0; mode = 0; corrupt_tag = -1;
    pulse_start();
    checks++;
    if (m_busy !== 1'b1 || m_wr_en !== 1'b0) begin
      errors++; $display("FAIL start_latency got busy=%b wr_en=%b want 1 0", m_busy, m_wr_en);
    end
    while (!m_done && t < 300) begin
      @(negedge clk); t++;
      if (m_wr_en) begin
        checks++;
        if (n_wr >= 4 || m_wr_address !== exp_wa[n_wr] || m_wr_data !== exp_wd[n_wr]) begin
          errors++; $display("FAIL wr_req%0d got %h/%h", n_wr, m_wr_address, m_wr_data);
        end
        n_wr++;
      end
      if (m_rd_en) begin
        checks++;
        if (n_rd >= 4 || m_rd_address !== exp_wa[n_rd]) begin
          errors++; $display("FAIL rd_req%0d got %h", n_rd, m_rd_address);
        end
        n_rd++;
      end
    end
    checks++;
    if (m_done !== 1'b1 || n_wr != 4 || n_rd != 4) begin
      errors++; $display("FAIL inorder_done got done=%b wr=%0d rd=%0d want 1 4 4", m_done, n_wr, n_rd);
    end
    checks++;
    if (m_rd_count !== 9'd4 || m_error !== 1'b0 || m_err_count !== 8'd0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL inorder_status got rdc=%0d err=%b errc=%0d busy=%b want 4 0 0 0",
                         m_rd_count, m_error, m_err_count, m_busy);
    end
  endtask

  task automatic test_corrupt();
    sel = 0; mode = 0; corrupt_tag = 32'h0012;
    pulse_start();
    checks++;
    if (m_done !== 1'b0 || m_rd_count !== 9'd0 || m_busy !== 1'b1) begin
      errors++; $display("FAIL restart_clear got done=%b rdc=%0d busy=%b want 0 0 1", m_done, m_rd_count, m_busy);
    end
    wait_done(300);
    checks++;
    if (m_done !== 1'b1 || m_rd_count !== 9'd4 || m_err_count !== 8'd1 || m_error !== 1'b1) begin
      errors++; $display("FAIL corrupt got done=%b rdc=%0d errc=%0d err=%b want 1 4 1 1",
                         m_done, m_rd_count, m_err_count, m_error);
    end
    corrupt_tag = -1;
  endtask

  task automatic test_dup_stray();
    int t = 0;
    sel = 0; mode = 3;
    pulse_start();
    tick(30);
    checks++;
    if (m_busy !== 1'b1 || m_rd_count !== 9'd0) begin
      errors++; $display("FAIL hold_state got busy=%b rdc=%0d want 1 0", m_busy, m_rd_count);
    end
    rel_target = rel_sent + 2;
    while (m_rd_count !== 9'd2 && t < 20) begin @(negedge clk); t++; end
    inj_a[0] = 16'h0011; inj_d[0] = 16'hA5D2;
    inj_a[1] = 16'h0100; inj_d[1] = 16'hA4C3;
    inj_target = inj_sent + 2;
    tick(6);
    checks++;
    if (m_err_count !== 8'd2 || m_rd_count !== 9'd2 || m_error !== 1'b1) begin
      errors++; $display("FAIL dup_stray got errc=%0d rdc=%0d err=%b want 2 2 1", m_err_count, m_rd_count, m_error);
    end
    rel_target = rel_target + 2;
    wait_done(100);
    checks++;
    if (m_done !== 1'b1 || m_rd_count !== 9'd4 || m_err_count !== 8'd2) begin
      errors++; $display("FAIL dup_stray_end got done=%b rdc=%0d errc=%0d want 1 4 2", m_done, m_rd_count, m_err_count);
    end
  endtask

  task automatic test_reset_midread();
    int n_rd = 0;
    sel = 0; mode = 3;
    pulse_start();
    for (int t = 0; t < 100 && n_rd < 3; t++) begin
      @(negedge clk);
      if (m_rd_en) n_rd++;
      if (n_rd == 3) reset = 1'b1;
    end
    checks++;
    if (n_rd != 3) begin
      errors++; $display("FAIL midread_issue got %0d reads want 3", n_rd);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rel_target = rel_target + 3;
    tick(10);
    checks++;
    if ({a_wr_address, a_wr_en, a_wr_data, a_rd_address, a_rd_en, a_busy, a_done, a_error,
         a_rd_count, a_err_count} !== '0) begin
      errors++; $display("FAIL late_returns got busy=%b done=%b err=%b rdc=%0d errc=%0d want all 0",
                         a_busy, a_done, a_error, a_rd_count, a_err_count);
    end
    mode = 0;
    pulse_start();
    wait_done(300);
    checks++;
    if (m_done !== 1'b1 || m_rd_count !== 9'd4 || m_error !== 1'b0 || m_err_count !== 8'd0) begin
      errors++; $display("FAIL post_reset_run got done=%b rdc=%0d err=%b errc=%0d want 1 4 0 0",
                         m_done, m_rd_count, m_error, m_err_count);
    end
  endtask

  task automatic test_reverse();
    sel = 1; mode = 2; rev_n = 8;
    pulse_start();
    wait_done(400);
    checks++;
    if (m_done !== 1'b1 || m_rd_count !== 9'd8 || m_error !== 1'b0 || m_err_count !== 8'd0) begin
      errors++; $display("FAIL reverse got done=%b rdc=%0d err=%b errc=%0d want 1 8 0 0",
                         m_done, m_rd_count, m_error, m_err_count);
    end
  endtask

  task automatic test_timeout();
    int n_rd = 0;
    sel = 2; mode = 3;
    pulse_start();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (m_rd_en) n_rd++;
    end
    checks++;
    if (n_rd != 2 || m_busy !== 1'b1 || m_done !== 1'b0) begin
      errors++; $display("FAIL max_outstanding got reads=%0d busy=%b done=%b want 2 1 0", n_rd, m_busy, m_done);
    end
    rel_target = rel_sent + 2;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (m_rd_en) n_rd++;
    end
    checks++;
    if (n_rd != 4 || m_rd_count !== 9'd2) begin
      errors++; $display("FAIL refill got reads=%0d rdc=%0d want 4 2", n_rd, m_rd_count);
    end
    tick(950);
    checks++;
    if (m_done !== 1'b0 || m_error !== 1'b0) begin
      errors++; $display("FAIL early_timeout got done=%b err=%b want 0 0", m_done, m_error);
    end
    wait_done(200);
    checks++;
    if (m_done !== 1'b1 || m_error !== 1'b1 || m_err_count !== 8'd1 || m_rd_count !== 9'd2 || m_busy !== 1'b0) begin
      errors++; $display("FAIL timeout got done=%b err=%b errc=%0d rdc=%0d busy=%b want 1 1 1 2 0",
                         m_done, m_error, m_err_count, m_rd_count, m_busy);
    end
    rel_target = rel_target + 2;
    tick(6);
    checks++;
    if (m_err_count !== 8'd1 || m_rd_count !== 9'd2 || m_done !== 1'b1) begin
      errors++; $display("FAIL done_ignores got errc=%0d rdc=%0d done=%b want 1 2 1", m_err_count, m_rd_count, m_done);
    end
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    test_reset();
    test_inorder();
    test_corrupt();
    test_dup_stray();
    test_reset_midread();
    test_reverse();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
